// File: rtl/ibex_pkg.sv
// ibex_pkg: shared fetch-bus definitions.
//   BUS_SIZE             instruction fetch data width
//   IFETCH_RESP_MAX_LAT  deepest supported SRAM read latency for the fetch responder
//   ifetch_resp_t        one slot of the responder's response pipeline {valid, err}
//   ifetch_addr_err()    address decode shared by the fetch responder
package ibex_pkg;

  localparam int unsigned BUS_SIZE            = 32;
  localparam int unsigned IFETCH_RESP_MAX_LAT = 4;

  typedef struct packed {
    logic valid;
    logic err;
  } ifetch_resp_t;

  // A fetch is in error when it falls outside [base, base+span) or is not
  // word aligned. The span is 33 bits so that a window touching the top of
  // the 4 GiB space does not wrap.
  function automatic logic ifetch_addr_err(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || ({1'b0, off} >= span) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ibex_ifetch_resp_lfsr.sv
// ibex_ifetch_resp_lfsr: pseudo-random grant stall generator for the fetch
// responder. A 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1, seed
// 16'hACE1) advances every cycle; stall_o is high when the two low bits are
// both zero, i.e. on roughly a quarter of all cycles.
//   clk_i    in   clock
//   rst_ni   in   asynchronous reset, active low
//   stall_o  out  withhold grant this cycle
module ibex_ifetch_resp_lfsr (
  input  logic clk_i,
  input  logic rst_ni,
  output logic stall_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  // Next LFSR state: right-shifting Fibonacci form, taps 16,14,13,11.
  always_comb begin
    feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = {feedback, lfsr_q[15:1]};
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/ibex_ifetch_responder.sv
// ibex_ifetch_responder: responder end of the core instruction-fetch bus.
// Accepts word fetches with the req/gnt/rvalid protocol, reads a synchronous
// instruction SRAM and returns rdata/err in grant order, exactly Latency
// cycles after each grant.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   instr_req_i       fetch request (held with instr_addr_i until granted)
//   instr_gnt_o       request accepted this cycle (combinational)
//   instr_addr_i      fetch byte address
//   instr_rvalid_o    response valid, one cycle per grant
//   instr_rdata_o     response data, zero when empty or in error
//   instr_err_o       response error, qualified by rvalid
//   mem_req_o         SRAM read strobe, same cycle as a good grant
//   mem_addr_o        SRAM word index
//   mem_rdata_i       SRAM read data, Latency cycles after mem_req_o
//   busy_o            fetches outstanding
//
// Build option: define IBEX_IFETCH_RESP_STALL_EN to withhold grants on
// pseudo-random cycles (ibex_ifetch_resp_lfsr); otherwise grant depends
// only on request and occupancy.
module ibex_ifetch_responder
  import ibex_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h0000_0000,
  parameter int unsigned MemWords       = 16384,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned BusSize        = BUS_SIZE
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        instr_req_i,
  output logic                        instr_gnt_o,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_rvalid_o,
  output logic [BusSize-1:0]          instr_rdata_o,
  output logic                        instr_err_o,
  output logic                        mem_req_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  input  logic [BusSize-1:0]          mem_rdata_i,
  output logic                        busy_o
);

  localparam int unsigned AddrW = $clog2(MemWords);
  // Illegal latencies are clamped to the deepest supported pipeline.
  localparam int unsigned Depth = (Latency > IFETCH_RESP_MAX_LAT) ? IFETCH_RESP_MAX_LAT :
                                  (Latency < 1) ? 1 : Latency;
  localparam logic [32:0] MemSpan = 33'(MemWords) << 2;
  localparam logic [2:0]  MaxOut  = 3'(MaxOutstanding);

  logic         stall;
  logic         gnt;
  logic         dec_err;
  logic [31:0]  addr_off;
  logic [2:0]   cnt_q;
  logic [2:0]   cnt_d;
  ifetch_resp_t resp_last;
  ifetch_resp_t [Depth-1:0] pipe_q;
  ifetch_resp_t [Depth-1:0] pipe_d;

`ifdef IBEX_IFETCH_RESP_STALL_EN
  ibex_ifetch_resp_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_o (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // A response leaving the pipeline does not free its slot until the next
  // cycle: the limit is checked against the registered count only.
  assign gnt         = instr_req_i & (cnt_q < MaxOut) & ~stall;
  assign instr_gnt_o = gnt;

  assign dec_err    = ifetch_addr_err(instr_addr_i, MemBase, MemSpan);
  assign addr_off   = instr_addr_i - MemBase;
  assign mem_req_o  = gnt & ~dec_err;
  assign mem_addr_o = AddrW'(addr_off >> 2);

  // Response pipeline: stage 0 captures every grant, older stages shift.
  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = gnt;
    pipe_d[0].err   = gnt & dec_err;
    for (int i = 1; i < Depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Outstanding count: +1 per grant, -1 per response, unchanged when both.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !instr_rvalid_o) begin
      cnt_d = cnt_q + 3'd1;
    end else if (!gnt && instr_rvalid_o) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers; reset discards in-flight responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
      cnt_q  <= 3'd0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  // The SRAM word lines up with the last pipeline stage, so read data is
  // passed straight through when that slot holds a good fetch.
  assign resp_last      = pipe_q[Depth-1];
  assign instr_rvalid_o = resp_last.valid;
  assign instr_err_o    = resp_last.valid & resp_last.err;
  assign instr_rdata_o  = (resp_last.valid && !resp_last.err) ? mem_rdata_i : '0;
  assign busy_o         = (cnt_q != 3'd0);

endmodule
